// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith/compare, iterative STEP-bit shifter for SLL/SRL/SRA.
// One op in flight: in_ready only in IDLE, result held in DONE until out_ready.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       alu_ctrl_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o
);
  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] STEP_L = SW'(STEP);

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
                         OP_SLL = 4'h4, OP_SLT = 4'h5, OP_SRL = 4'h6, OP_SRA = 4'h7,
                         OP_SGE = 4'h8, OP_XOR = 4'h9;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SW-1:0]    rem_q, rem_d;
  logic             right_q, right_d;
  logic             arith_q, arith_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;

  logic             accept;
  logic             is_shift;
  logic [SW-1:0]    shamt;
  logic             lt;
  logic [WIDTH-1:0] alu_res;
  logic [SW-1:0]    step_amt;
  logic [WIDTH-1:0] acc_shift;

  assign accept   = in_valid_i && (state_q == IDLE);
  assign is_shift = (alu_ctrl_i == OP_SLL) || (alu_ctrl_i == OP_SRL) || (alu_ctrl_i == OP_SRA);
  assign shamt    = src_b_i[SW-1:0];
  assign lt       = $signed(src_a_i) < $signed(src_b_i);

  // Shift codes only reach this path with a zero shift amount, so they pass A through.
  always_comb begin
    alu_res = '0;
    case (alu_ctrl_i)
      OP_ADD:                 alu_res = src_a_i + src_b_i;
      OP_SUB:                 alu_res = src_a_i - src_b_i;
      OP_AND:                 alu_res = src_a_i & src_b_i;
      OP_OR:                  alu_res = src_a_i | src_b_i;
      OP_XOR:                 alu_res = src_a_i ^ src_b_i;
      OP_SLT:                 alu_res = {{(WIDTH-1){1'b0}}, lt};
      OP_SGE:                 alu_res = {{(WIDTH-1){1'b0}}, ~lt};
      OP_SLL, OP_SRL, OP_SRA: alu_res = src_a_i;
      default:                alu_res = '0;
    endcase
  end

  // The accumulator MSB stays equal to the latched sign during SRA, so >>> fills correctly.
  assign step_amt = (rem_q > STEP_L) ? STEP_L : rem_q;
  always_comb begin
    acc_shift = acc_q << step_amt;
    if (right_q) begin
      if (arith_q) acc_shift = $signed(acc_q) >>> step_amt;
      else         acc_shift = acc_q >> step_amt;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    right_d  = right_q;
    arith_d  = arith_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_shift && (shamt != '0)) begin
            acc_d   = src_a_i;
            rem_d   = shamt;
            right_d = (alu_ctrl_i != OP_SLL);
            arith_d = (alu_ctrl_i == OP_SRA);
            state_d = SHIFT;
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            state_d  = DONE;
          end
        end
      end
      SHIFT: begin
        acc_d = acc_shift;
        rem_d = rem_q - step_amt;
        if (rem_q == step_amt) begin
          result_d = acc_shift;
          zero_d   = (acc_shift == '0);
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      rem_q    <= '0;
      right_q  <= 1'b0;
      arith_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      right_q  <= right_d;
      arith_q  <= arith_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign result_o    = result_q;
  assign zero_o      = zero_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: STEP=1 and STEP=4 instances against a behavioural op/latency model.
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  ctrl;
  logic [31:0] sa, sb;
  logic        iv   [2];
  logic        ir   [2];
  logic        ov   [2];
  logic        ordy [2];
  logic [31:0] res  [2];
  logic        z    [2];

  alu_exec_unit #(.WIDTH(32), .STEP(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(iv[0]), .in_ready_o(ir[0]),
    .alu_ctrl_i(ctrl), .src_a_i(sa), .src_b_i(sb),
    .out_valid_o(ov[0]), .out_ready_i(ordy[0]), .result_o(res[0]), .zero_o(z[0]));

  alu_exec_unit #(.WIDTH(32), .STEP(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(iv[1]), .in_ready_o(ir[1]),
    .alu_ctrl_i(ctrl), .src_a_i(sa), .src_b_i(sb),
    .out_valid_o(ov[1]), .out_ready_i(ordy[1]), .result_o(res[1]), .zero_o(z[1]));

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
  endtask

  function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (c)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a << sh;
      4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: return a >> sh;
      4'd7: return 32'($signed(a) >>> sh);
      4'd8: return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      4'd9: return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  // Cycles spent in SHIFT after the accept edge.
  function automatic int shift_cycles(input int s, input logic [3:0] c, input logic [31:0] b);
    int sh, st;
    sh = int'(b[4:0]);
    st = (s == 1) ? 4 : 1;
    if ((c == 4'd4 || c == 4'd6 || c == 4'd7) && sh > 0) return (sh + st - 1) / st;
    return 0;
  endfunction

  always @(posedge clk) cyc++;

  bit          pend  [2] = '{0, 0};
  logic [31:0] exp_r [2];
  int          vcyc  [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        pend[d] = 0;
        chk($sformatf("rst_ov%0d", d),  32'(ov[d]), 32'd0);
        chk($sformatf("rst_rdy%0d", d), 32'(ir[d]), 32'd1);
        chk($sformatf("rst_res%0d", d), res[d],     32'd0);
        chk($sformatf("rst_z%0d", d),   32'(z[d]),  32'd1);
      end else if (pend[d]) begin
        if (cyc < vcyc[d]) begin
          chk($sformatf("busy_ov%0d", d),  32'(ov[d]), 32'd0);
          chk($sformatf("busy_rdy%0d", d), 32'(ir[d]), 32'd0);
        end else begin
          chk($sformatf("done_ov%0d", d),  32'(ov[d]), 32'd1);
          chk($sformatf("done_rdy%0d", d), 32'(ir[d]), 32'd0);
          chk($sformatf("done_res%0d", d), res[d],     exp_r[d]);
          chk($sformatf("done_z%0d", d),   32'(z[d]),  32'(exp_r[d] == 32'd0));
          if (ordy[d]) pend[d] = 0;
        end
      end else begin
        chk($sformatf("idle_ov%0d", d),  32'(ov[d]), 32'd0);
        chk($sformatf("idle_rdy%0d", d), 32'(ir[d]), 32'd1);
        if (iv[d]) begin
          pend[d]  = 1;
          exp_r[d] = model(ctrl, sa, sb);
          vcyc[d]  = cyc + 1 + shift_cycles(d, ctrl, sb);
        end
      end
    end
  end

  task automatic run_op(input int s, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input int hold, output logic [31:0] r, output logic zf, output int lat);
    int guard;
    ctrl = c; sa = a; sb = b; iv[s] = 1'b1;
    guard = 0;
    while (!ir[s] && guard < 200) begin @(posedge clk); #1; guard++; end
    chk("accept_wait", 32'(ir[s]), 32'd1);
    @(posedge clk); #1;
    iv[s] = 1'b0;
    lat = 1;
    while (!ov[s] && lat < 200) begin
      ctrl = 4'($urandom); sa = $urandom; sb = $urandom;
      @(posedge clk); #1;
      lat++;
    end
    chk("done_wait", 32'(ov[s]), 32'd1);
    r  = res[s];
    zf = z[s];
    for (int i = 0; i < hold; i++) begin
      ctrl = 4'($urandom); sa = $urandom; sb = $urandom;
      @(posedge clk); #1;
      chk("hold_res", res[s], r);
      chk("hold_z", 32'(z[s]), 32'(zf));
      chk("hold_ov", 32'(ov[s]), 32'd1);
      chk("hold_rdy", 32'(ir[s]), 32'd0);
    end
    ordy[s] = 1'b1;
    @(posedge clk); #1;
    ordy[s] = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got cycle %0d want completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    logic        zf;
    int          lat;
    logic [3:0]  c;
    logic [31:0] a, b;
    int          s;

    rst_n = 1'b0;
    iv[0] = 1'b0; iv[1] = 1'b0; ordy[0] = 1'b0; ordy[1] = 1'b0;
    ctrl = '0; sa = '0; sb = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    chk("model_add_wrap", model(4'd0, 32'hFFFF_FFFF, 32'd1), 32'd0);
    chk("model_sra", model(4'd7, 32'h8000_0000, 32'd4), 32'hF800_0000);
    chk("model_sge_neg", model(4'd8, 32'hFFFF_FFFE, 32'd1), 32'd0);
    chk("model_lat_s4", 32'(shift_cycles(1, 4'd4, 32'd31)), 32'd8);

    run_op(0, 4'd0, 32'hFFFF_FFFF, 32'd1, 0, r, zf, lat);
    chk("t1_res", r, 32'd0); chk("t1_z", 32'(zf), 32'd1); chk("t1_lat", 32'(lat), 32'd1);

    run_op(0, 4'd1, 32'd5, 32'd7, 0, r, zf, lat);
    chk("t2_sub", r, 32'hFFFF_FFFE); chk("t2_sub_z", 32'(zf), 32'd0);
    run_op(0, 4'd5, 32'hFFFF_FFFE, 32'd1, 0, r, zf, lat);
    chk("t2_slt", r, 32'd1);
    run_op(0, 4'd8, 32'hFFFF_FFFE, 32'd1, 0, r, zf, lat);
    chk("t2_sge", r, 32'd0); chk("t2_sge_z", 32'(zf), 32'd1);

    run_op(0, 4'd4, 32'd1, 32'd31, 0, r, zf, lat);
    chk("t3_sll", r, 32'h8000_0000); chk("t3_lat", 32'(lat), 32'd32);

    run_op(0, 4'd7, 32'h8000_0000, 32'd4, 0, r, zf, lat);
    chk("t4_sra", r, 32'hF800_0000); chk("t4_sra_lat", 32'(lat), 32'd5);
    run_op(0, 4'd6, 32'h8000_0000, 32'd4, 0, r, zf, lat);
    chk("t4_srl", r, 32'h0800_0000);
    run_op(0, 4'd7, 32'h8000_0000, 32'd0, 0, r, zf, lat);
    chk("t4_sh0", r, 32'h8000_0000); chk("t4_sh0_lat", 32'(lat), 32'd1);

    run_op(0, 4'd3, 32'h00F0_0000, 32'h0000_000F, 5, r, zf, lat);
    chk("t5_or", r, 32'h00F0_000F);
    chk("t5_next_rdy", 32'(ir[0]), 32'd1);
    run_op(0, 4'd9, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 0, r, zf, lat);
    chk("t5_xor", r, 32'd0); chk("t5_xor_z", 32'(zf), 32'd1);

    ctrl = 4'd4; sa = 32'h1234_5678; sb = 32'd20; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_ov", 32'(ov[0]), 32'd0); chk("t6_res", res[0], 32'd0);
    chk("t6_z", 32'(z[0]), 32'd1);   chk("t6_rdy", 32'(ir[0]), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6_rel_ov", 32'(ov[0]), 32'd0); chk("t6_rel_rdy", 32'(ir[0]), 32'd1);
    run_op(0, 4'hF, 32'hFFFF_FFFF, 32'h1234_5678, 0, r, zf, lat);
    chk("t6_bad", r, 32'd0); chk("t6_bad_z", 32'(zf), 32'd1); chk("t6_bad_lat", 32'(lat), 32'd1);
    run_op(1, 4'd4, 32'd1, 32'd31, 0, r, zf, lat);
    chk("t6_s4_sll", r, 32'h8000_0000); chk("t6_s4_lat", 32'(lat), 32'd9);
    run_op(1, 4'd7, 32'h8000_0001, 32'd6, 0, r, zf, lat);
    chk("t6_s4_sra", r, 32'hFE00_0000); chk("t6_s4_sra_lat", 32'(lat), 32'd3);

    repeat (200) begin
      s = int'($urandom_range(0, 1));
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = $urandom_range(0, 40);
        2: a = a | 32'h8000_0000;
        default: ;
      endcase
      run_op(s, c, a, b, int'($urandom_range(0, 2)), r, zf, lat);
      chk("rnd_lat", 32'(lat), 32'(1 + shift_cycles(s, c, b)));
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
